// File: rtl/exception_controller_pkg.sv
// Shared state encoding, exception codes and timing constants for the exception controller.
// Pure declarations: no logic, no latency, no flow control.
package ExcPkg;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACK  = 2'd1,
      MASK = 2'd2
   } exc_state_t;

   localparam int CODE_W = 4;
   localparam logic [CODE_W-1:0] CODE_ILLEGAL = 4'd1;
   localparam logic [CODE_W-1:0] CODE_IRQ0    = 4'd2;

   localparam int MASK_TIMEOUT = 8;
   localparam int CNT_W        = 4;
endpackage

// File: rtl/exception_controller_sync.sv
// Parameterized 2-flop synchronizer bus with async active-low clear.
// Latency 2 Clock edges; no flow control, each bit is synchronized independently.
module SyncBus #(
   parameter int W = 4
) (
   input  logic         Clock,
   input  logic         Reset_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   logic [W-1:0] meta;

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end
endmodule

// File: rtl/exception_controller.sv
// Arbitrates illegal-op, IRQ and branch sources into Flush/ExcAck/ExcTake and the exception vector.
// IRQ: ACK 3 edges after request; IllegalOp: next edge. Stall holds ACK with outputs frozen.
module exception_controller
   import ExcPkg::*;
#(
   parameter int          NUM_IRQ  = 4,
   parameter logic [31:0] VEC_BASE = 32'h8000_0000
) (
   input  logic               Clock,
   input  logic               Reset_n,
   input  logic [NUM_IRQ-1:0] IrqReq,
   output logic [NUM_IRQ-1:0] IrqAck,
   input  logic               IllegalOp,
   input  logic               SupervisorMode,
   input  logic               Stall,
   input  logic               BranchTaken,
   output logic               Flush,
   output logic               ExcAck,
   output logic               ExcTake,
   output logic [31:0]        ExcVector
);
   exc_state_t         state, state_nxt;
   logic [CODE_W-1:0]  code_reg, code_nxt, win_code;
   logic [CNT_W-1:0]   mask_cnt, cnt_nxt;
   logic [NUM_IRQ-1:0] irq_sync, irq_qual, ack_nxt;
   logic               any_src;

   SyncBus #(.W(NUM_IRQ)) u_sync (
      .Clock   (Clock),
      .Reset_n (Reset_n),
      .d       (IrqReq),
      .q       (irq_sync)
   );

   assign irq_qual = SupervisorMode ? '0 : irq_sync;

   // Scan downward so the lowest-numbered qualifying IRQ is the last write and wins.
   always_comb begin
      any_src  = 1'b0;
      win_code = '0;
      if (IllegalOp) begin
         any_src  = 1'b1;
         win_code = CODE_ILLEGAL;
      end else begin
         for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (irq_qual[i]) begin
               any_src  = 1'b1;
               win_code = CODE_IRQ0 + CODE_W'(i);
            end
         end
      end
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state    <= IDLE;
         code_reg <= '0;
         mask_cnt <= '0;
         IrqAck   <= '0;
      end else begin
         state    <= state_nxt;
         code_reg <= code_nxt;
         mask_cnt <= cnt_nxt;
         IrqAck   <= ack_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      code_nxt  = code_reg;
      cnt_nxt   = mask_cnt;
      ack_nxt   = '0;
      case (state)
         IDLE: begin
            if (any_src) begin
               state_nxt = ACK;
               code_nxt  = win_code;
            end
         end
         ACK: begin
            if (!Stall) begin
               state_nxt = MASK;
               cnt_nxt   = '0;
               // Registered so the acknowledge pulse is glitch-free; it follows the consuming edge.
               if (code_reg >= CODE_IRQ0)
                  ack_nxt = NUM_IRQ'(1) << (code_reg - CODE_IRQ0);
            end
         end
         MASK: begin
            cnt_nxt = mask_cnt + 1'b1;
            if (SupervisorMode || mask_cnt == CNT_W'(MASK_TIMEOUT - 1))
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign ExcAck    = (state == ACK);
   assign ExcTake   = (state == ACK);
   assign Flush     = BranchTaken | (state == ACK);
   assign ExcVector = VEC_BASE + 32'({code_reg, 2'b00});
endmodule

// File: doc/exception_controller.md
# exception_controller

Generates the pipeline `Flush`, `ExcAck` and exception-vector controls that the fetch-side instruction registers consume. It arbitrates three sources: illegal-opcode traps from decode, synchronized external interrupt requests, and taken branches/jumps. When it accepts an exception, it makes the instruction registers inject `BNE(R31,0,XP)` for one cycle and steers the PC to the selected vector. It sits between the decode stage, the interrupt sources and the PC mux.

## Interface
Parameters:
- `NUM_IRQ`, 4: number of external interrupt lines (1..8).
- `VEC_BASE`, 32'h8000_0000: reset vector. Other vectors are `VEC_BASE + 4*code`.

Ports:
- `Clock` in 1: single clock; all state on rising edge.
- `Reset_n` in 1: asynchronous, active-low reset.
- `IrqReq` in `NUM_IRQ`: level-sensitive interrupt requests, asynchronous to `Clock`.
- `IrqAck` out `NUM_IRQ`: one-hot, one-cycle acknowledge of the serviced line.
- `IllegalOp` in 1: decode stage holds an illegal opcode (synchronous).
- `SupervisorMode` in 1: PC[31] of the decode-stage instruction. Interrupts are masked while it is 1.
- `Stall` in 1: pipeline stalled (instruction-register `Enable` low).
- `BranchTaken` in 1: branch/jump resolved taken this cycle.
- `Flush` out 1: to instruction registers.
- `ExcAck` out 1: to instruction registers; selects BNE injection over NOP.
- `ExcTake` out 1: PC mux selects `ExcVector`.
- `ExcVector` out 32: target address.

## Operation
- Interrupt lines pass through a 2-flop synchronizer per line, giving `IrqSync`.
- Exception codes:
  - Illegal opcode = 1.
  - IRQ i = 2+i.
  - Priority: `IllegalOp` > IRQ0 > IRQ1 > …
- An interrupt qualifies only when `SupervisorMode`=0. `IllegalOp` always qualifies.
- State machine (encoding in package):
  - IDLE → ACK when any source qualifies. The winning code is latched into `CodeReg`.
  - ACK: `Flush`=`ExcAck`=`ExcTake`=1, and `ExcVector = VEC_BASE + 4*CodeReg`.
    - Stays in ACK while `Stall`=1, with outputs held stable.
    - Leaves when `Stall`=0, going to MASK. The injection and PC redirect complete on that edge.
    - `IrqAck[i]` pulses on that exit cycle only, and only for an IRQ code.
  - MASK: no new exception is accepted.
    - → IDLE once `SupervisorMode`=1 is sampled (handler running).
    - → IDLE after `MASK_TIMEOUT`=8 cycles, whichever comes first. The timeout covers a handler at a user-mode vector.
- `Flush = BranchTaken | (state==ACK)`.
- `ExcAck` is 1 only in ACK. A branch-only flush therefore injects NOP.
- Simultaneous events:
  - `BranchTaken` during ACK: the exception wins and `ExcAck` stays 1.
  - `IllegalOp` and an IRQ together: the IRQ stays pending in the synchronizer and is reconsidered after MASK.
- Sources are not latched beyond the synchronizer. A request dropped before acceptance is lost, and that is by design.
- Source handshake: a source must deassert within 4 cycles of `IrqAck`. MASK covers this window when the handler enters supervisor mode.
- Reset, including mid-ACK: state IDLE, `CodeReg`=0, synchronizers cleared. All outputs are 0 and `ExcVector`=`VEC_BASE`.

## Timing
- IRQ latency: `IrqReq` rise → 2 cycles synchronizing → 1 cycle to IDLE decision → ACK entered on the 3rd edge.
  - `Flush`/`ExcAck` are high in cycle 3 and consumed at edge 4 when `Stall`=0.
- IllegalOp latency: sampled in IDLE → ACK on the next edge.
- Outputs:
  - All outputs except the `BranchTaken` term of `Flush` decode from registered state (Moore), so they are glitch-free.
  - `Flush` has a combinational path from `BranchTaken` only.
- `ExcVector` changes only on entry to ACK.

## Structure
- Package `ExcPkg`:
  - state enum (IDLE, ACK, MASK);
  - code width;
  - `CODE_ILLEGAL`=1 and `CODE_IRQ0`=2;
  - `MASK_TIMEOUT`=8.
- Sub-module `SyncBus` holds the parameterized 2-flop synchronizer (width `NUM_IRQ`, async active-low clear).
- The priority encoder, FSM and timeout counter stay inline.

## Test plan
- Reset release, no inputs → all outputs 0 and `ExcVector`=32'h8000_0000 for 20 cycles.
- `IrqReq[1]` rises, `SupervisorMode`=0 →
  - `Flush`=`ExcAck`=`ExcTake`=1 in cycle 3 with `ExcVector`=32'h8000_000C;
  - one-cycle `IrqAck`=4'b0010;
  - `SupervisorMode`=1 two cycles later → IDLE.
- `IllegalOp`, `IrqReq[0]` and `BranchTaken` together with `Stall`=1 for 3 cycles →
  - ACK holds with `ExcVector`=32'h8000_0004 for 4 cycles;
  - no `IrqAck`;
  - IRQ0 taken after MASK exits (vector 32'h8000_0008).
- `BranchTaken` pulse in IDLE → `Flush`=1 in the same cycle, with `ExcAck`=0 and `ExcTake`=0.
- `IrqReq[2]` held while `SupervisorMode`=1 → no ACK. Dropping `SupervisorMode` → ACK with vector 32'h8000_0010.
- `Reset_n` low during ACK → all outputs 0 immediately, with no `IrqAck` pulse.
- MASK with `SupervisorMode` held 0 → return to IDLE after exactly 8 cycles.
